// File: rtl/rv_test_pkg.sv
// rv_test_pkg
// Shared definitions for the riscv-tests completion monitor and its bench:
//   mon_state_t          - monitor state encoding
//   TOHOST_PASS          - tohost value that signals a passing test
//   TOHOST_ADDR_DEFAULT  - default byte address of the tohost word
package rv_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } mon_state_t;

    localparam logic [31:0] TOHOST_PASS         = 32'd1;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/rv_sat_counter.sv
// rv_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset, clears the count
//   en     - increment this cycle (ignored once saturated)
//   clear  - synchronous clear, wins over en
//   count  - current value
module rv_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_test_monitor.sv
// rv_test_monitor
// Snoops the core's store bus for the riscv-tests tohost handshake and latches
// a sticky PASS / FAIL(testnum) / TIMEOUT (/ HANG) verdict. Cycle and retire
// counters run while the test is running and freeze once a verdict is reached.
// Optional self-loop detection is compiled in with RV_TEST_MONITOR_HANG_DETECT_EN.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   st_valid/addr/wdata/be   - snooped store
//   ret_valid, ret_pc        - one retirement per cycle and its PC
//   done                     - any verdict reached
//   pass/fail/timeout/hang   - one-hot verdict flags while done
//   testnum                  - failing test number (st_wdata >> 1)
//   cycles, retired          - RUN cycle and retirement counts
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int               XLEN           = 32,
    parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEFAULT),
    parameter int               TIMEOUT_CYCLES = 5000,
    parameter int               CNT_W          = 32,
    parameter int               HANG_LIMIT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st_valid,
    input  logic [XLEN-1:0]     st_addr,
    input  logic [XLEN-1:0]     st_wdata,
    input  logic [XLEN/8-1:0]   st_be,
    input  logic                ret_valid,
    input  logic [XLEN-1:0]     ret_pc,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic                hang,
    output logic [XLEN-2:0]     testnum,
    output logic [CNT_W-1:0]    cycles,
    output logic [CNT_W-1:0]    retired
);

    mon_state_t state, state_nxt;

    logic hit, pass_hit, fail_hit;
    logic active, start, count_en, count_clear;
    logic timeout_hit, hang_hit;

    // Only a full-width store to the tohost word counts; zero and even
    // (syscall) values fall through both decodes and are ignored.
    assign hit      = st_valid && (st_addr == TOHOST_ADDR) && (&st_be);
    assign pass_hit = hit && (st_wdata == XLEN'(TOHOST_PASS));
    assign fail_hit = hit && st_wdata[0] && !pass_hit;

    // The retirement that leaves IDLE is itself counted, so the counters are
    // enabled on that cycle as well as throughout RUN.
    assign active      = (state == ST_RUN);
    assign start       = (state == ST_IDLE) && ret_valid;
    assign count_en    = active || start;
    assign count_clear = (state == ST_IDLE) && !ret_valid;
    assign timeout_hit = active && (cycles == CNT_W'(TIMEOUT_CYCLES - 1));

    rv_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en),
        .clear (count_clear),
        .count (cycles)
    );

    rv_sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en && ret_valid),
        .clear (count_clear),
        .count (retired)
    );

`ifdef RV_TEST_MONITOR_HANG_DETECT_EN
    localparam int SAME_W = $clog2(HANG_LIMIT + 1);

    logic [XLEN-1:0]   last_pc;
    logic [SAME_W-1:0] same_cnt;

    // The starting retirement seeds last_pc so a core spinning from its very
    // first instruction is caught after HANG_LIMIT repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc  <= '0;
            same_cnt <= '0;
        end else if (start) begin
            last_pc  <= ret_pc;
            same_cnt <= '0;
        end else if (active && ret_valid) begin
            last_pc  <= ret_pc;
            same_cnt <= (ret_pc == last_pc) ? same_cnt + 1'b1 : '0;
        end
    end

    assign hang_hit = active && ret_valid && (ret_pc == last_pc) &&
                      (same_cnt == SAME_W'(HANG_LIMIT - 1));
    assign hang     = (state == ST_HANG);
`else
    logic unused_pc;
    assign unused_pc = ^ret_pc;
    assign hang_hit  = 1'b0;
    assign hang      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A tohost hit always beats hang and timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pass_hit)       state_nxt = ST_PASS;
                else if (fail_hit)  state_nxt = ST_FAIL;
                else if (ret_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (pass_hit)         state_nxt = ST_PASS;
                else if (fail_hit)    state_nxt = ST_FAIL;
                else if (hang_hit)    state_nxt = ST_HANG;
                else if (timeout_hit) state_nxt = ST_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            testnum <= '0;
        end else if (((state == ST_IDLE) || active) && fail_hit) begin
            testnum <= st_wdata[XLEN-1:1];
        end
    end

    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign timeout = (state == ST_TIMEOUT);
    assign done    = pass || fail || timeout || hang;

endmodule

// File: tb/tb_rv_test_monitor.sv
// tb_rv_test_monitor
// Directed bench for rv_test_monitor: reset, start of run, pass/fail decode,
// ignored stores, timeout, hit-vs-timeout priority, async reset, same-PC loop.
module tb_rv_test_monitor;
    import rv_test_pkg::*;

    localparam int XLEN = 32;
    localparam int TO   = 40;
    localparam int CW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic            done, pass, fail, timeout, hang;
    logic [XLEN-2:0] testnum;
    logic [CW-1:0]   cycles, retired;

    int n_checks = 0;
    int n_fail   = 0;

    rv_test_monitor #(
        .XLEN           (XLEN),
        .TOHOST_ADDR    (TOHOST_ADDR_DEFAULT),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW),
        .HANG_LIMIT     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .hang      (hang),
        .testnum   (testnum),
        .cycles    (cycles),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid  = 1'b0;
        st_addr   = '0;
        st_wdata  = '0;
        st_be     = '0;
        ret_valid = 1'b0;
        ret_pc    = '0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = addr;
        st_wdata = data;
        st_be    = be;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // One retirement in IDLE; afterwards cycles=1, retired=1.
    task automatic start_run(input logic [31:0] pc);
        ret_valid = 1'b1;
        ret_pc    = pc;
        step();
        ret_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if ({done, pass, fail, timeout, hang} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {done, pass, fail, timeout, hang});
        end
        n_checks++;
        if (cycles !== '0 || retired !== '0 || testnum !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: got cycles=%0d retired=%0d testnum=%0d expected 0 0 0", cycles, retired, testnum);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (dut.state !== ST_IDLE || cycles !== '0) begin
            n_fail++;
            $display("[TB] FAIL idle_hold: got state=%0d cycles=%0d expected 0 0", dut.state, cycles);
        end
    endtask

    task automatic test_start();
        do_reset();
        start_run(32'h0);
        n_checks++;
        if (dut.state !== ST_RUN || cycles !== 32'd1 || retired !== 32'd1 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start: got state=%0d cycles=%0d retired=%0d done=%b expected 1 1 1 0", dut.state, cycles, retired, done);
        end
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
        step();
        n_checks++;
        if (cycles !== 32'd3 || retired !== 32'd2) begin
            n_fail++;
            $display("[TB] FAIL run_count: got cycles=%0d retired=%0d expected 3 2", cycles, retired);
        end
    endtask

    task automatic test_pass();
        do_reset();
        start_run(32'h0);
        for (int i = 0; i < 17; i++) begin
            ret_valid = (i % 2 == 1);
            step();
        end
        store(TOHOST_ADDR_DEFAULT, TOHOST_PASS, 4'hF);
        ret_valid = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if ({done, pass, fail, timeout, hang} !== 5'b11000) begin
            n_fail++;
            $display("[TB] FAIL pass_flags: got %b expected 11000", {done, pass, fail, timeout, hang});
        end
        n_checks++;
        if (cycles !== 32'd19 || retired !== 32'd10) begin
            n_fail++;
            $display("[TB] FAIL pass_counts: got cycles=%0d retired=%0d expected 19 10", cycles, retired);
        end
        ret_valid = 1'b1;
        store(TOHOST_ADDR_DEFAULT, 32'h7, 4'hF);
        step();
        idle_inputs();
        step();
        step();
        n_checks++;
        if (cycles !== 32'd19 || retired !== 32'd10 || pass !== 1'b1 || fail !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pass_frozen: got cycles=%0d retired=%0d pass=%b fail=%b expected 19 10 1 0", cycles, retired, pass, fail);
        end
    endtask

    task automatic test_fail();
        do_reset();
        start_run(32'h0);
        store(TOHOST_ADDR_DEFAULT, 32'h0000_0007, 4'hF);
        step();
        idle_inputs();
        n_checks++;
        if ({done, pass, fail, timeout} !== 4'b1010 || testnum !== 31'd3 || cycles !== 32'd2) begin
            n_fail++;
            $display("[TB] FAIL fail_decode: got flags=%b testnum=%0d cycles=%0d expected 1010 3 2", {done, pass, fail, timeout}, testnum, cycles);
        end
        store(TOHOST_ADDR_DEFAULT, TOHOST_PASS, 4'hF);
        step();
        idle_inputs();
        n_checks++;
        if (fail !== 1'b1 || pass !== 1'b0 || testnum !== 31'd3) begin
            n_fail++;
            $display("[TB] FAIL fail_sticky: got fail=%b pass=%b testnum=%0d expected 1 0 3", fail, pass, testnum);
        end
        do_reset();
        start_run(32'h0);
        store(TOHOST_ADDR_DEFAULT, 32'h8000_0003, 4'hF);
        step();
        idle_inputs();
        n_checks++;
        if (fail !== 1'b1 || testnum !== 31'h4000_0001) begin
            n_fail++;
            $display("[TB] FAIL fail_wide: got fail=%b testnum=%h expected 1 40000001", fail, testnum);
        end
    endtask

    task automatic test_ignored_and_timeout();
        do_reset();
        start_run(32'h0);
        store(TOHOST_ADDR_DEFAULT, TOHOST_PASS, 4'h1);
        step();
        store(TOHOST_ADDR_DEFAULT, 32'h2, 4'hF);
        step();
        store(TOHOST_ADDR_DEFAULT, 32'h0, 4'hF);
        step();
        store(TOHOST_ADDR_DEFAULT + 32'h4, TOHOST_PASS, 4'hF);
        step();
        idle_inputs();
        n_checks++;
        if (done !== 1'b0 || dut.state !== ST_RUN) begin
            n_fail++;
            $display("[TB] FAIL ignored_stores: got done=%b state=%0d expected 0 1", done, dut.state);
        end
        for (int i = 4; i < TO - 2; i++) step();
        n_checks++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got timeout=%b done=%b expected 0 0", timeout, done);
        end
        step();
        n_checks++;
        if ({done, pass, fail, timeout} !== 4'b1001 || cycles !== 32'(TO)) begin
            n_fail++;
            $display("[TB] FAIL timeout: got flags=%b cycles=%0d expected 1001 %0d", {done, pass, fail, timeout}, cycles, TO);
        end
        step();
        step();
        n_checks++;
        if (cycles !== 32'(TO) || timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_frozen: got cycles=%0d timeout=%b expected %0d 1", cycles, timeout, TO);
        end
    endtask

    task automatic test_hit_on_timeout();
        do_reset();
        start_run(32'h0);
        for (int i = 0; i < TO - 2; i++) step();
        store(TOHOST_ADDR_DEFAULT, TOHOST_PASS, 4'hF);
        step();
        idle_inputs();
        n_checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || cycles !== 32'(TO)) begin
            n_fail++;
            $display("[TB] FAIL hit_beats_timeout: got pass=%b timeout=%b cycles=%0d expected 1 0 %0d", pass, timeout, cycles, TO);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run(32'h0);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({done, pass, fail, timeout, hang} !== 5'b0 || cycles !== '0 || retired !== '0 || dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL async_reset_run: got flags=%b cycles=%0d retired=%0d state=%0d expected 0 0 0 0", {done, pass, fail, timeout, hang}, cycles, retired, dut.state);
        end
        do_reset();
        start_run(32'h0);
        store(TOHOST_ADDR_DEFAULT, TOHOST_PASS, 4'hF);
        step();
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (pass !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_verdict: got pass=%b done=%b expected 0 0", pass, done);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_same_pc();
        do_reset();
        start_run(32'h100);
        ret_valid = 1'b1;
        ret_pc    = 32'h100;
        for (int i = 0; i < 16; i++) step();
        idle_inputs();
`ifdef RV_TEST_MONITOR_HANG_DETECT_EN
        n_checks++;
        if ({done, pass, fail, timeout, hang} !== 5'b10001 || retired !== 32'd17) begin
            n_fail++;
            $display("[TB] FAIL hang: got flags=%b retired=%0d expected 10001 17", {done, pass, fail, timeout, hang}, retired);
        end
`else
        n_checks++;
        if (done !== 1'b0 || hang !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL no_hang: got done=%b hang=%b expected 0 0", done, hang);
        end
        for (int i = 16; i < TO - 1; i++) step();
        n_checks++;
        if ({done, timeout, hang} !== 3'b110 || retired !== 32'd17) begin
            n_fail++;
            $display("[TB] FAIL loop_timeout: got flags=%b retired=%0d expected 110 17", {done, timeout, hang}, retired);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_start();
        test_pass();
        test_fail();
        test_ignored_and_timeout();
        test_hit_on_timeout();
        test_async_reset();
        test_same_pc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
